// File: rtl/sccb_arbiter_if.sv
// sccb_arbiter_if: requester/SCCB-master bus for sccb_arbiter.
// slave = arbiter side, master = requesters + SCCB master side.
interface sccb_arbiter_if;
    logic        i_req0;
    logic [15:0] i_wr0;
    logic        i_req1;
    logic [15:0] i_wr1;
    logic        o_ack0;
    logic        o_ack1;
    logic [1:0]  o_grant;
    logic        o_m_start;
    logic [6:0]  o_m_addr;
    logic [15:0] o_m_wdata;
    logic        i_m_ready;
    logic        o_busy;

    modport slave (
        input  i_req0, i_wr0, i_req1, i_wr1, i_m_ready,
        output o_ack0, o_ack1, o_grant, o_m_start,
        output o_m_addr, o_m_wdata, o_busy
    );

    modport master (
        output i_req0, i_wr0, i_req1, i_wr1, i_m_ready,
        input  o_ack0, o_ack1, o_grant, o_m_start,
        input  o_m_addr, o_m_wdata, o_busy
    );
endinterface

// File: rtl/sccb_arbiter.sv
// sccb_arbiter: two-requester arbiter in front of one SCCB write master.
// Ports: i_clk, i_rstn (async, active-low); bus (sccb_arbiter_if.slave):
//   i_req0/i_wr0, i_req1/i_wr1 requests; o_ack0/o_ack1 done pulses;
//   o_grant owner; o_m_start/o_m_addr/o_m_wdata/i_m_ready master side;
//   o_busy high outside IDLE.
// Macro SCCB_ARB_RR_EN selects round-robin instead of fixed priority.
module sccb_arbiter #(
    parameter logic [7:0] CAM_I2C_ADDR = 8'h42,
    parameter int         GAP_CYC      = 16
) (
    input logic           i_clk,
    input logic           i_rstn,
    sccb_arbiter_if.slave bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_GAP       = 3'd4;
    localparam logic [7:0] GAP_LAST    = 8'(GAP_CYC - 1);

    logic [2:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  grant_q, grant_d;
    logic [15:0] wdata_q, wdata_d;
    logic        start_q, start_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic [1:0]  win;

`ifdef SCCB_ARB_RR_EN
    // last_q: requester granted most recently (1 after reset so 0 wins first)
    logic last_q, last_d;

    always_comb begin
        win = 2'b00;
        if (bus.i_req0 && bus.i_req1)
            win = last_q ? 2'b01 : 2'b10;
        else if (bus.i_req0)
            win = 2'b01;
        else if (bus.i_req1)
            win = 2'b10;
    end

    always_comb begin
        last_d = last_q;
        if (state_q == S_IDLE && bus.i_m_ready && win != 2'b00)
            last_d = win[1];
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) last_q <= 1'b1;
        else         last_q <= last_d;
    end
`else
    always_comb begin
        win = 2'b00;
        if (bus.i_req0)
            win = 2'b01;
        else if (bus.i_req1)
            win = 2'b10;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        wdata_d = wdata_q;
        start_d = 1'b0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.i_m_ready && win != 2'b00) begin
                    grant_d = win;
                    wdata_d = win[0] ? bus.i_wr0 : bus.i_wr1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                start_d = 1'b1;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!bus.i_m_ready)
                    state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (bus.i_m_ready) begin
                    ack0_d  = grant_q[0];
                    ack1_d  = grant_q[1];
                    grant_d = 2'b00;
                    cnt_d   = 8'd0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            grant_q <= 2'b00;
            wdata_q <= 16'h0000;
            start_q <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            wdata_q <= wdata_d;
            start_q <= start_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

    assign bus.o_ack0    = ack0_q;
    assign bus.o_ack1    = ack1_q;
    assign bus.o_grant   = grant_q;
    assign bus.o_m_start = start_q;
    assign bus.o_m_addr  = CAM_I2C_ADDR[7:1];
    assign bus.o_m_wdata = wdata_q;
    assign bus.o_busy    = (state_q != S_IDLE);
endmodule

// File: tb/tb_sccb_arbiter.sv
// tb_sccb_arbiter: directed vector bench for sccb_arbiter.
// Table of single transactions plus hand-written reset/ready sequences.
module tb_sccb_arbiter;
    localparam int GAP = 16;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    sccb_arbiter_if bus();

    sccb_arbiter #(
        .CAM_I2C_ADDR(8'h42),
        .GAP_CYC     (GAP)
    ) dut (
        .i_clk (clk),
        .i_rstn(rstn),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        r0;
        logic        r1;
        logic [15:0] w0;
        logic [15:0] w1;
        logic        mut;
        logic [1:0]  g;
        logic [15:0] wd;
    } vec_t;

    vec_t tv[7];

    // One complete transaction; the SCCB master stays busy 3 cycles.
    task automatic txn(input vec_t v);
        int lat;
        int n;
        bit seen;
        bit ok;
        bus.i_req0    = v.r0;
        bus.i_req1    = v.r1;
        bus.i_wr0     = v.w0;
        bus.i_wr1     = v.w1;
        bus.i_m_ready = 1'b1;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 50) begin
            @(negedge clk);
            lat++;
            if (v.mut && bus.o_grant != 2'b00) begin
                bus.i_wr0 = 16'hFFFF;
                bus.i_wr1 = 16'hFFFF;
            end
            seen = bus.o_m_start;
        end
        chk("start_latency", lat, 2);
        chk("grant", bus.o_grant, v.g);
        chk("wdata_at_start", bus.o_m_wdata, v.wd);
        chk("m_addr", bus.o_m_addr, 7'h21);
        chk("busy", bus.o_busy, 1'b1);
        chk("no_ack_with_start", {bus.o_ack1, bus.o_ack0}, 2'b00);
        bus.i_m_ready = 1'b0;
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.o_m_start || bus.o_grant != v.g ||
                bus.o_m_wdata != v.wd || bus.o_ack0 || bus.o_ack1)
                ok = 1'b0;
        end
        chk("hold_while_busy", ok, 1'b1);
        bus.i_m_ready = 1'b1;
        n = 0;
        while (!(bus.o_ack0 || bus.o_ack1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ack_delay", n, 1);
        chk("ack_lines", {bus.o_ack1, bus.o_ack0}, v.g);
        chk("wdata_at_ack", bus.o_m_wdata, v.wd);
        chk("grant_cleared", bus.o_grant, 2'b00);
        chk("start_low_at_ack", bus.o_m_start, 1'b0);
        if (v.g[0]) bus.i_req0 = 1'b0;
        if (v.g[1]) bus.i_req1 = 1'b0;
        @(negedge clk);
        chk("ack_one_pulse", {bus.o_ack1, bus.o_ack0}, 2'b00);
        n = 1;
        while (bus.o_busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("gap_cycles", n, GAP);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int n;
        vec_t v;

        tv[0] = '{1'b1, 1'b0, 16'h1280, 16'h0000, 1'b0, 2'b01, 16'h1280};
        tv[1] = '{1'b0, 1'b1, 16'h0000, 16'h3A04, 1'b0, 2'b10, 16'h3A04};
        tv[2] = '{1'b1, 1'b1, 16'h1100, 16'h3A04, 1'b0, 2'b01, 16'h1100};
        tv[3] = '{1'b0, 1'b1, 16'h1100, 16'h3A04, 1'b1, 2'b10, 16'h3A04};
        tv[4] = '{1'b1, 1'b0, 16'h5555, 16'h3A04, 1'b0, 2'b01, 16'h5555};
`ifdef SCCB_ARB_RR_EN
        tv[5] = '{1'b1, 1'b1, 16'h1100, 16'h3A04, 1'b0, 2'b10, 16'h3A04};
        tv[6] = '{1'b1, 1'b0, 16'h1100, 16'h3A04, 1'b0, 2'b01, 16'h1100};
`else
        tv[5] = '{1'b1, 1'b1, 16'h1100, 16'h3A04, 1'b0, 2'b01, 16'h1100};
        tv[6] = '{1'b0, 1'b1, 16'h1100, 16'h3A04, 1'b0, 2'b10, 16'h3A04};
`endif

        rstn          = 1'b0;
        bus.i_req0    = 1'b0;
        bus.i_req1    = 1'b0;
        bus.i_wr0     = 16'h0000;
        bus.i_wr1     = 16'h0000;
        bus.i_m_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_grant", bus.o_grant, 2'b00);
        chk("rst_wdata", bus.o_m_wdata, 16'h0000);
        chk("rst_outs", {bus.o_m_start, bus.o_ack1, bus.o_ack0, bus.o_busy},
            4'b0000);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            txn(tv[i]);

        // request held while master not ready for 50 cycles
        bus.i_m_ready = 1'b0;
        bus.i_req0    = 1'b1;
        bus.i_wr0     = 16'h2222;
        ok = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (bus.o_m_start || bus.o_grant != 2'b00 || bus.o_busy)
                ok = 1'b0;
        end
        chk("no_issue_not_ready", ok, 1'b1);
        v = '{1'b1, 1'b0, 16'h2222, 16'h0000, 1'b0, 2'b01, 16'h2222};
        txn(v);

        // request withdrawn before grant
        bus.i_m_ready = 1'b0;
        bus.i_req1    = 1'b1;
        bus.i_wr1     = 16'h7777;
        repeat (3) @(negedge clk);
        bus.i_req1    = 1'b0;
        bus.i_m_ready = 1'b1;
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.o_m_start || bus.o_grant != 2'b00 || bus.o_busy ||
                bus.o_ack0 || bus.o_ack1)
                ok = 1'b0;
        end
        chk("withdrawn_silent", ok, 1'b1);

        // reset pulse while waiting for the master to finish
        bus.i_req0 = 1'b1;
        bus.i_wr0  = 16'hAAAA;
        n = 0;
        while (!bus.o_m_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_seq_start", n, 2);
        bus.i_m_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_seq_busy", {bus.o_busy, bus.o_grant}, 3'b101);
        rstn = 1'b0;
        #1;
        chk("async_rst_grant", bus.o_grant, 2'b00);
        chk("async_rst_wdata", bus.o_m_wdata, 16'h0000);
        chk("async_rst_outs",
            {bus.o_m_start, bus.o_ack1, bus.o_ack0, bus.o_busy}, 4'b0000);
        @(negedge clk);
        rstn = 1'b1;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.o_m_start || bus.o_ack0 || bus.o_ack1 ||
                bus.o_grant != 2'b00)
                ok = 1'b0;
        end
        chk("rst_no_ack_no_issue", ok, 1'b1);
        v = '{1'b1, 1'b0, 16'hAAAA, 16'h0000, 1'b0, 2'b01, 16'hAAAA};
        txn(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sccb_arbiter.md
SCCB_ARBITER -- requirements
Module: sccb_arbiter

Interface
REQ-001 SHALL have parameter CAM_I2C_ADDR, default 8'h42, 8-bit camera write address; bits [7:1] are driven as the 7-bit slave address.
REQ-002 SHALL have parameter GAP_CYC, default 16, idle clock cycles enforced between consecutive transactions (range 1..255).
REQ-003 i_clk  input  1  system clock (27 MHz).
REQ-004 i_rstn  input  1  reset; one clock; asynchronous, active-low.
REQ-005 i_req0  input  1  requester 0 (init config) write request, held until ack.
REQ-006 i_wr0  input  16  requester 0 write word {REG_ADDR, REG_DATA}.
REQ-007 i_req1  input  1  requester 1 (runtime filter/control) write request, held until ack.
REQ-008 i_wr1  input  16  requester 1 write word {REG_ADDR, REG_DATA}.
REQ-009 o_ack0, o_ack1  output  1 each  one-cycle completion pulse to the owning requester.
REQ-010 o_grant  output  2  one-hot current owner; 2'b00 when idle.
REQ-011 o_m_start  output  1  one-cycle start pulse to the SCCB master.
REQ-012 o_m_addr  output  7  slave address = CAM_I2C_ADDR[7:1].
REQ-013 o_m_wdata  output  16  latched write word of the granted requester.
REQ-014 i_m_ready  input  1  SCCB master idle/ready level.
REQ-015 o_busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
REQ-017 IDLE: when any request is high and i_m_ready=1, SHALL select a winner (REQ-024), latch its word into o_m_wdata, set o_grant, and go to ISSUE next cycle.
REQ-018 IDLE with a request pending and i_m_ready=0: SHALL stay in IDLE with no grant.
REQ-019 ISSUE: SHALL assert o_m_start for exactly one cycle, then go to WAIT_BUSY.
REQ-020 WAIT_BUSY: SHALL go to WAIT_DONE on i_m_ready=0; o_m_start SHALL NOT be reasserted.
REQ-021 WAIT_DONE: on i_m_ready=1, SHALL pulse o_ackN of the granted requester for exactly one cycle, clear o_grant, and go to GAP.
REQ-022 GAP: SHALL count GAP_CYC cycles, then return to IDLE; requests arriving in GAP SHALL be held pending, not dropped.
REQ-023 o_m_wdata and o_grant SHALL remain stable from latch through the WAIT_DONE exit; requester input changes after grant SHALL be ignored.
REQ-024 Arbitration (default): fixed priority; requester 0 wins simultaneous requests.
REQ-025 A request deasserted before grant SHALL be withdrawn silently, with no ack.
REQ-026 The requester SHALL drop its request on the cycle after its ack; a request still high on that cycle SHALL be treated as a new transaction after GAP.
REQ-027 At most one o_ackN SHALL be high in any cycle; o_m_start and o_ackN SHALL never coincide.
REQ-028 Latency, request to o_m_start, from IDLE with i_m_ready=1 SHALL be 2 cycles.

Reset
REQ-029 i_rstn=0 SHALL asynchronously force state IDLE, o_m_start=0, o_ack0=o_ack1=0, o_grant=2'b00, o_m_wdata=16'h0000, o_busy=0, GAP counter=0.
REQ-030 Reset mid-transaction SHALL abandon the transaction with no ack; after release the FSM SHALL wait in IDLE for i_m_ready=1 before issuing.

Configuration
REQ-031 Macro SCCB_ARB_RR_EN defined: arbitration SHALL be round-robin; on simultaneous requests the requester not granted most recently wins; the last-granted pointer SHALL reset to requester 1, giving requester 0 first win.
REQ-032 Macro SCCB_ARB_RR_EN undefined: fixed priority per REQ-024; no pointer register SHALL exist.

Verification
REQ-033 i_req0=1 with i_wr0=16'h1280, master modelled ready->busy 3 cycles->ready -> o_m_start 2 cycles after request, o_m_wdata=16'h1280, o_m_addr=7'h21, o_ack0 one pulse.
REQ-034 i_req0 and i_req1 asserted on the same cycle (16'h1100, 16'h3A04), RR off -> requester 0 served first, requester 1 served after 16 GAP cycles; two ack pulses, no overlap.
REQ-035 Same stimulus as REQ-034 repeated twice, SCCB_ARB_RR_EN on -> grant order 0,1,1,0 is not produced; required order is 0,1,0,1.
REQ-036 i_rstn pulsed low during WAIT_DONE -> all outputs at reset values immediately, no ack, reissue after i_m_ready=1.
REQ-037 Request held while i_m_ready=0 for 50 cycles -> no o_m_start until ready, then normal 2-cycle issue.
REQ-038 i_wr1 changed from 16'h3A04 to 16'hFFFF after grant -> o_m_wdata stays 16'h3A04 through the ack.
